// File: rtl/time_set_ctrl_pkg.sv
// Shared types, limits and BCD helpers for the front-panel time/alarm entry controller.
package time_set_ctrl_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EDIT_HOUR,
    S_EDIT_MIN,
    S_LOAD
  } state_t;

  localparam int HOUR_MAX            = 23;
  localparam int MIN_MAX             = 59;
  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_LOAD_HOLD       = 12;
  localparam int DEF_TIMEOUT         = 255;

  function automatic logic hour_ok(input logic [1:0] h1, input logic [3:0] h0);
    return (h0 <= 4'd9) && ((int'(h1) * 10 + int'(h0)) <= HOUR_MAX);
  endfunction

  function automatic logic min_ok(input logic [3:0] m1, input logic [3:0] m0);
    return (m0 <= 4'd9) && ((int'(m1) * 10 + int'(m0)) <= MIN_MAX);
  endfunction

  // Returns {h1, h0} advanced by one hour, wrapping HOUR_MAX to 00.
  function automatic logic [5:0] inc_hour(input logic [1:0] h1, input logic [3:0] h0);
    if ((int'(h1) * 10 + int'(h0)) >= HOUR_MAX) return '0;
    if (h0 == 4'd9) return {h1 + 2'd1, 4'd0};
    return {h1, h0 + 4'd1};
  endfunction

  // Returns {m1, m0} advanced by one minute, wrapping MIN_MAX to 00 without carry out.
  function automatic logic [7:0] inc_min(input logic [3:0] m1, input logic [3:0] m0);
    if ((int'(m1) * 10 + int'(m0)) >= MIN_MAX) return '0;
    if (m0 == 4'd9) return {m1 + 4'd1, 4'd0};
    return {m1, m0 + 4'd1};
  endfunction

endpackage

// File: rtl/time_set_ctrl_button_conditioner.sv
// Raw push-button to one-cycle press pulse: 2-flop synchronizer, debounce, rising-edge detect.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          r_pulse;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_cnt    <= '0;
      r_pulse  <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_pulse <= 1'b0;
      // Any sample matching the accepted level restarts the stability count.
      if (r_sync2 != r_stable) begin
        if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          r_stable <= r_sync2;
          r_pulse  <= r_sync2;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

  assign o_pulse = r_pulse;

endmodule

// File: rtl/time_set_ctrl.sv
// Front-panel time/alarm entry: edits a BCD HH:MM seeded from the clock and strobes LD_time/LD_alarm.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int LOAD_HOLD       = DEF_LOAD_HOLD,
  parameter int TIMEOUT         = DEF_TIMEOUT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       btn_set,
  input  logic       sel_alarm,
  input  logic [1:0] cur_H1,
  input  logic [3:0] cur_H0,
  input  logic [3:0] cur_M1,
  input  logic [3:0] cur_M0,
  output logic [1:0] H_in1,
  output logic [3:0] H_in0,
  output logic [3:0] M_in1,
  output logic [3:0] M_in0,
  output logic       LD_time,
  output logic       LD_alarm,
  output logic       editing,
  output logic       field_min
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(LOAD_HOLD + 1);

  logic w_mode, w_inc, w_set;

  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
    .clk(clk), .reset(reset), .i_btn(btn_mode), .o_pulse(w_mode));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
    .clk(clk), .reset(reset), .i_btn(btn_inc), .o_pulse(w_inc));
  button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk(clk), .reset(reset), .i_btn(btn_set), .o_pulse(w_set));

  state_t        r_state;
  logic [1:0]    r_h1;
  logic [3:0]    r_h0, r_m1, r_m0;
  logic          r_target;
  logic [TW-1:0] r_to_cnt;
  logic [LW-1:0] r_ld_cnt;
  logic          r_ld_time, r_ld_alarm, r_editing, r_field_min;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_h1        <= '0;
      r_h0        <= '0;
      r_m1        <= '0;
      r_m0        <= '0;
      r_target    <= 1'b0;
      r_to_cnt    <= '0;
      r_ld_cnt    <= '0;
      r_ld_time   <= 1'b0;
      r_ld_alarm  <= 1'b0;
      r_editing   <= 1'b0;
      r_field_min <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_mode) begin
            r_state     <= S_EDIT_HOUR;
            r_editing   <= 1'b1;
            r_field_min <= 1'b0;
            r_target    <= sel_alarm;
            r_to_cnt    <= '0;
            if (hour_ok(cur_H1, cur_H0)) {r_h1, r_h0} <= {cur_H1, cur_H0};
            else                         {r_h1, r_h0} <= '0;
            if (min_ok(cur_M1, cur_M0))  {r_m1, r_m0} <= {cur_M1, cur_M0};
            else                         {r_m1, r_m0} <= '0;
          end
        end
        S_EDIT_HOUR, S_EDIT_MIN: begin
          // Press priority is set > mode > inc; a lower press in the same cycle is dropped.
          if (w_set) begin
            r_state     <= S_LOAD;
            r_editing   <= 1'b0;
            r_field_min <= 1'b0;
            r_ld_cnt    <= '0;
            r_ld_time   <= ~r_target;
            r_ld_alarm  <= r_target;
          end else if (w_mode) begin
            r_state     <= (r_state == S_EDIT_HOUR) ? S_EDIT_MIN : S_EDIT_HOUR;
            r_field_min <= (r_state == S_EDIT_HOUR);
            r_to_cnt    <= '0;
          end else if (w_inc) begin
            if (r_state == S_EDIT_HOUR) {r_h1, r_h0} <= inc_hour(r_h1, r_h0);
            else                        {r_m1, r_m0} <= inc_min(r_m1, r_m0);
            r_to_cnt <= '0;
          end else if (r_to_cnt == TW'(TIMEOUT - 1)) begin
            r_state     <= S_IDLE;
            r_editing   <= 1'b0;
            r_field_min <= 1'b0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_LOAD: begin
          if (r_ld_cnt == LW'(LOAD_HOLD - 1)) begin
            r_state    <= S_IDLE;
            r_ld_time  <= 1'b0;
            r_ld_alarm <= 1'b0;
          end else begin
            r_ld_cnt <= r_ld_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign H_in1     = r_h1;
  assign H_in0     = r_h0;
  assign M_in1     = r_m1;
  assign M_in0     = r_m0;
  assign LD_time   = r_ld_time;
  assign LD_alarm  = r_ld_alarm;
  assign editing   = r_editing;
  assign field_min = r_field_min;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed self-checking bench for time_set_ctrl; digits compared as 16-bit BCD 0xHHMM.
module tb_time_set_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       btn_mode = 1'b0, btn_inc = 1'b0, btn_set = 1'b0, sel_alarm = 1'b0;
  logic [1:0] cur_H1 = '0;
  logic [3:0] cur_H0 = '0, cur_M1 = '0, cur_M0 = '0;
  logic [1:0] H_in1;
  logic [3:0] H_in0, M_in1, M_in0;
  logic       LD_time, LD_alarm, editing, field_min;
  logic [15:0] disp;

  int n_checks = 0;
  int n_errors = 0;

  time_set_ctrl #(.DEBOUNCE_CYCLES(4), .LOAD_HOLD(12), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .btn_mode(btn_mode), .btn_inc(btn_inc), .btn_set(btn_set), .sel_alarm(sel_alarm),
    .cur_H1(cur_H1), .cur_H0(cur_H0), .cur_M1(cur_M1), .cur_M0(cur_M0),
    .H_in1(H_in1), .H_in0(H_in0), .M_in1(M_in1), .M_in0(M_in0),
    .LD_time(LD_time), .LD_alarm(LD_alarm), .editing(editing), .field_min(field_min));

  always #5 clk = ~clk;
  assign disp = {2'b00, H_in1, H_in0, M_in1, M_in0};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_cur(input logic [15:0] v);
    cur_H1 = v[13:12]; cur_H0 = v[11:8]; cur_M1 = v[7:4]; cur_M0 = v[3:0];
  endtask

  // 0 = mode, 1 = inc, 2 = set; hold long enough to debounce, release long enough to settle.
  task automatic press(input int which);
    case (which)
      0: btn_mode = 1'b1;
      1: btn_inc  = 1'b1;
      default: btn_set = 1'b1;
    endcase
    repeat (8) @(negedge clk);
    btn_mode = 1'b0; btn_inc = 1'b0; btn_set = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  // Holds set for 30 cycles and counts the high cycles of each strobe.
  task automatic set_and_count(output int nt, output int na, output int both);
    nt = 0; na = 0; both = 0;
    btn_set = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (LD_time) nt++;
      if (LD_alarm) na++;
      if (LD_time && LD_alarm) both++;
    end
    btn_set = 1'b0; btn_mode = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  initial begin
    int nt, na, both, fm_seen, waited;

    // Test 1: reset state, then time load of 13:19.
    set_cur(16'h1019);
    repeat (3) @(negedge clk);
    check("rst_digits", disp, 16'h0000);
    check("rst_ld", {LD_time, LD_alarm}, 2'b00);
    check("rst_edit", {editing, field_min}, 2'b00);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    press(1);
    check("idle_inc_ignored", {editing, disp}, 17'h0_0000);
    press(0);
    check("t1_seed", disp, 16'h1019);
    check("t1_editing", {editing, field_min}, 2'b10);
    repeat (3) press(1);
    check("t1_hour13", disp, 16'h1319);
    set_and_count(nt, na, both);
    check("t1_ld_time_len", nt, 12);
    check("t1_ld_alarm_len", na, 0);
    check("t1_digits_after", disp, 16'h1319);
    check("t1_back_idle", editing, 1'b0);

    // Test 2: alarm target, hour 23->00, minute 58->59->00->01.
    set_cur(16'h2358); sel_alarm = 1'b1;
    press(0);
    sel_alarm = 1'b0;
    check("t2_seed", disp, 16'h2358);
    press(1);
    check("t2_hour_wrap", disp, 16'h0058);
    press(0);
    check("t2_field_min", {editing, field_min}, 2'b11);
    repeat (3) press(1);
    check("t2_min_wrap", disp, 16'h0001);
    set_and_count(nt, na, both);
    check("t2_ld_alarm_len", na, 12);
    check("t2_ld_time_len", nt, 0);
    check("t2_digits", disp, 16'h0001);

    // Test 3: bouncing inc gives one increment; pulse 6 cycles after the final rising edge.
    set_cur(16'h1019);
    press(0);
    check("t3_seed", disp, 16'h1019);
    btn_inc = 1'b1; @(negedge clk);
    btn_inc = 1'b0; @(negedge clk);
    btn_inc = 1'b1;
    repeat (5) @(negedge clk);
    check("t3_no_pulse_yet", {dut.w_inc, disp}, 17'h0_1019);
    @(negedge clk);
    check("t3_pulse_at_6", dut.w_inc, 1'b1);
    @(negedge clk);
    check("t3_inc_applied", disp, 16'h1119);
    repeat (3) @(negedge clk);
    btn_inc = 1'b0;
    repeat (10) @(negedge clk);
    check("t3_single_inc", disp, 16'h1119);

    // Test 4: mode and set together in EDIT_HOUR -> load wins, field stays hour.
    btn_mode = 1'b1; btn_set = 1'b1;
    nt = 0; fm_seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (LD_time) nt++;
      if (field_min) fm_seen++;
    end
    btn_mode = 1'b0; btn_set = 1'b0;
    repeat (8) @(negedge clk);
    check("t4_ld_time_len", nt, 12);
    check("t4_no_field_adv", fm_seen, 0);
    check("t4_digits", disp, 16'h1119);

    // Test 5: invalid seed 27:61 sanitised to 00:00, then edit timeout without load.
    set_cur(16'h2761);
    press(0);
    check("t5_sanitised", disp, 16'h0000);
    press(1);
    nt = 0; na = 0;
    repeat (220) begin
      @(negedge clk);
      if (LD_time) nt++;
      if (LD_alarm) na++;
    end
    check("t5_still_editing", editing, 1'b1);
    repeat (40) begin
      @(negedge clk);
      if (LD_time) nt++;
      if (LD_alarm) na++;
    end
    check("t5_timed_out", editing, 1'b0);
    check("t5_no_strobe", nt + na, 0);
    check("t5_digits_kept", disp, 16'h0100);

    // Test 6: reset asserted in the 5th cycle of LD_time.
    set_cur(16'h1019);
    press(0);
    btn_set = 1'b1;
    waited = 0;
    while (!LD_time && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    check("t6_ld_seen", LD_time, 1'b1);
    repeat (4) @(negedge clk);
    check("t6_ld_cycle5", {LD_time, disp}, 17'h1_1019);
    #2 reset = 1'b0;
    #1;
    check("t6_async_ld", {LD_time, LD_alarm}, 2'b00);
    check("t6_async_digits", disp, 16'h0000);
    btn_set = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    press(1);
    press(1);
    check("t6_idle_after", {editing, LD_time, disp}, 18'h0_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/time_set_ctrl.md
Name: time_set_ctrl

Overview:
- Front-panel time/alarm entry controller: the writer side of the alarm clock's load interface.
- Conditions three push-buttons, edits a BCD HH:MM value seeded from the clock's current outputs, then drives H_in*/M_in* with LD_time or LD_alarm.
- LD is held long enough for the clock's slow 1 s tick to sample it.
- Sits between panel buttons and the alarm clock core.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable samples required before a button level is accepted.
- LOAD_HOLD, 12, cycles LD_time/LD_alarm stay high; must exceed one clk_1s period (10 clk).
- TIMEOUT, 255, idle cycles in an edit state before abort without load.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- btn_mode  in  1  raw button; enter edit / advance field
- btn_inc  in  1  raw button; increment selected field
- btn_set  in  1  raw button; commit edited value
- sel_alarm  in  1  level; sampled on edit entry: 1 = alarm target, 0 = time target
- cur_H1  in  2, cur_H0 in 4, cur_M1 in 4, cur_M0 in 4  current clock digits, seed value for edit
- H_in1  out  2, H_in0 out 4, M_in1 out 4, M_in0 out 4  edited BCD value to clock
- LD_time  out  1  load-time strobe
- LD_alarm  out  1  load-alarm strobe
- editing  out  1  high in EDIT_HOUR/EDIT_MIN
- field_min  out  1  0 = hour field selected, 1 = minute field (for display blink)

Behaviour:
- Reset (reset=0, async): state IDLE; all digit outputs 0; LD_time=LD_alarm=0; editing=0; field_min=0; counters 0; target=0.
- Button conditioning, per button:
  - 2-flop synchronizer, then debounce: accepted level changes after DEBOUNCE_CYCLES equal samples.
  - Press = one-cycle pulse on accepted 0->1 transition.
  - Latency from raw edge to pulse: 2 + DEBOUNCE_CYCLES cycles. Holding a button produces one pulse only.
- Same-cycle priority: set > mode > inc; lower-priority pulses that cycle are discarded.
- IDLE:
  - mode press -> EDIT_HOUR; copy cur_* into edit regs; latch target=sel_alarm; timeout counter cleared.
  - inc/set presses ignored.
- EDIT_HOUR:
  - inc: hour +1 in BCD. H0 9->0 carries H1; 23 -> 00.
  - mode -> EDIT_MIN.
  - set -> LOAD.
- EDIT_MIN:
  - inc: minute +1 in BCD. M0 9->0 carries M1; 59 -> 00; no carry into hour.
  - mode -> EDIT_HOUR.
  - set -> LOAD.
- Seed sanitising: out-of-range seed digits (hour > 23 or minute > 59) are forced to 00 for that field on entry.
- Timeout: counter increments each cycle in EDIT states and clears on any accepted press. Reaching TIMEOUT -> IDLE, no LD strobe, outputs retain last edit value.
- LOAD:
  - Exactly one of LD_time/LD_alarm (per target) is high for LOAD_HOLD cycles, then IDLE.
  - Digits are stable for the whole window and one cycle beyond.
  - All presses ignored during LOAD.
- Outputs:
  - H_in*/M_in* always reflect the edit regs and hold their value in IDLE.
  - LD_* are registered, never both high.
  - editing and field_min are registered decodes of state.
- Reset mid-LOAD: strobe drops immediately (async), state IDLE.

Decomposition:
- Shared package:
  - state encoding (IDLE, EDIT_HOUR, EDIT_MIN, LOAD);
  - BCD limit constants (HOUR_MAX 23, MIN_MAX 59);
  - default parameter values.
- Sub-module button_conditioner (sync + debounce + rising-edge pulse, parameter DEBOUNCE_CYCLES), instantiated three times.

Test Plan:
- Reset, cur=10:19, sel_alarm=0; press mode; 3x inc; set -> H_in=13, M_in=19; LD_time high exactly 12 cycles; LD_alarm stays 0.
- cur=23:58, sel_alarm=1; mode, inc -> hour 00; mode, 3x inc -> minute 01 (wrap via 59->00); set -> LD_alarm 12 cycles with 00:01.
- Button bounce: toggle btn_inc every cycle for 3 cycles, then hold high 10 cycles -> exactly one increment, pulse appears 6 cycles after the stable edge.
- mode and set pressed the same cycle in EDIT_HOUR -> LOAD entered (set wins); field does not advance.
- Enter edit, no presses for 255 cycles -> editing falls to 0, no LD strobe, digits keep edited value.
- Assert reset low during cycle 5 of LD_time -> LD_time and digits go 0 the same cycle; after release, state IDLE and inc presses are ignored.
